// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects, counts retired instructions, flags illegal encodings.
module multicycle_controller #(
  parameter int OP_W  = 6,
  parameter int FN_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic [FN_W-1:0]  funct,
  input  logic             zero,
  output logic             dffEnable,
  output logic             irWrite,
  output logic             iOrD,
  output logic             memWrite,
  output logic             memToReg,
  output logic             regDst,
  output logic             writeEnable,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       pcSrc,
  output logic [3:0]       aluControl,
  output logic [CNT_W-1:0] instrCount,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RT   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  localparam logic [FN_W-1:0] FN_ADD = FN_W'(6'b100000);
  localparam logic [FN_W-1:0] FN_SUB = FN_W'(6'b100010);
  localparam logic [FN_W-1:0] FN_AND = FN_W'(6'b100100);
  localparam logic [FN_W-1:0] FN_OR  = FN_W'(6'b100101);
  localparam logic [FN_W-1:0] FN_SLT = FN_W'(6'b101010);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t     state;
  state_t     next;
  logic       bad;
  logic       retire;
  logic [3:0] fn_alu;
  logic       fn_ok;

  always_comb begin
    fn_alu = ALU_ADD;
    fn_ok  = 1'b1;
    case (funct)
      FN_ADD:  fn_alu = ALU_ADD;
      FN_SUB:  fn_alu = ALU_SUB;
      FN_AND:  fn_alu = ALU_AND;
      FN_OR:   fn_alu = ALU_OR;
      FN_SLT:  fn_alu = ALU_SLT;
      default: fn_ok  = 1'b0;
    endcase
  end

  always_comb begin
    next   = S_FETCH;
    bad    = 1'b0;
    retire = 1'b0;
    case (state)
      S_FETCH: next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_RT:        next = S_EXEC;
          OP_BEQ:       next = S_BRANCH;
          OP_ADDI:      next = S_ADDIEX;
          OP_J:         next = S_JUMP;
          default:      bad  = 1'b1;
        endcase
      end
      S_MEMADR: next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next = S_MEMWB;
      S_EXEC: begin
        next = S_ALUWB;
        bad  = ~fn_ok;
      end
      S_ADDIEX: next = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB,
      S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
      default: next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      instrCount <= '0;
      illegal    <= 1'b0;
    end else begin
      state <= next;
      if (retire) instrCount <= instrCount + CNT_W'(1);
      if (bad) illegal <= 1'b1;
    end
  end

  // Gated by reset so strobes drop the instant reset asserts.
  always_comb begin
    dffEnable   = 1'b0;
    irWrite     = 1'b0;
    iOrD        = 1'b0;
    memWrite    = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    writeEnable = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    pcSrc       = 2'b00;
    aluControl  = ALU_AND;
    if (reset) begin
      case (state)
        S_FETCH: begin
          irWrite    = 1'b1;
          dffEnable  = 1'b1;
          aluSrcB    = 2'b01;
          aluControl = ALU_ADD;
        end
        S_DECODE: begin
          aluSrcB    = 2'b11;
          aluControl = ALU_ADD;
        end
        S_MEMADR, S_ADDIEX: begin
          aluSrcA    = 1'b1;
          aluSrcB    = 2'b10;
          aluControl = ALU_ADD;
        end
        S_MEMRD: iOrD = 1'b1;
        S_MEMWB: begin
          memToReg    = 1'b1;
          writeEnable = 1'b1;
        end
        S_MEMWR: begin
          iOrD     = 1'b1;
          memWrite = 1'b1;
        end
        S_EXEC: begin
          aluSrcA    = 1'b1;
          aluControl = fn_alu;
        end
        S_ALUWB: begin
          regDst      = 1'b1;
          writeEnable = 1'b1;
        end
        S_BRANCH: begin
          aluSrcA    = 1'b1;
          aluControl = ALU_SUB;
          pcSrc      = 2'b01;
          dffEnable  = zero;
        end
        S_ADDIWB: writeEnable = 1'b1;
        S_JUMP: begin
          pcSrc     = 2'b10;
          dffEnable = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed + random instruction streams
// checked cycle-by-cycle against a per-instruction-class reference model.
module tb_multicycle_controller;

  localparam int CW = 4;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3;
  localparam int K_ADDI = 4, K_J = 5, K_ILL = 6;

  typedef struct packed {
    logic       dff;
    logic       irw;
    logic       iord;
    logic       mw;
    logic       m2r;
    logic       rdst;
    logic       we;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] pcs;
    logic [3:0] alu;
  } ov_t;

  logic          clk;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          zero;
  logic          dffEnable, irWrite, iOrD, memWrite;
  logic          memToReg, regDst, writeEnable, aluSrcA;
  logic [1:0]    aluSrcB, pcSrc;
  logic [3:0]    aluControl;
  logic [CW-1:0] instrCount;
  logic          illegal;

  int tests = 0;
  int fails = 0;
  int m_cnt = 0;
  logic m_ill = 1'b0;

  multicycle_controller #(.OP_W(6), .FN_W(6), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .dffEnable(dffEnable), .irWrite(irWrite),
    .iOrD(iOrD), .memWrite(memWrite), .memToReg(memToReg),
    .regDst(regDst), .writeEnable(writeEnable), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcSrc(pcSrc), .aluControl(aluControl),
    .instrCount(instrCount), .illegal(illegal)
  );

  ov_t obs;
  assign obs = '{dffEnable, irWrite, iOrD, memWrite, memToReg, regDst,
                 writeEnable, aluSrcA, aluSrcB, pcSrc, aluControl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic fn_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100,
                      6'b100101, 6'b101010};
  endfunction

  function automatic int lat(input int k);
    case (k)
      K_LW:             return 5;
      K_SW, K_R, K_ADDI: return 4;
      K_BEQ, K_J:       return 3;
      default:          return 2;
    endcase
  endfunction

  function automatic logic [5:0] op_of(input int k);
    case (k)
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_R:     return 6'b000000;
      K_BEQ:   return 6'b000100;
      K_ADDI:  return 6'b001000;
      K_J:     return 6'b000010;
      default: return 6'b111111;
    endcase
  endfunction

  // Expected control word for cycle c of an instruction of class k.
  function automatic ov_t expv(input int k, input int c,
                               input logic [5:0] fn, input logic z);
    ov_t e = '0;
    if (c == 0) begin
      e.dff = 1; e.irw = 1; e.asb = 2'b01; e.alu = 4'b0010;
    end else if (c == 1) begin
      e.asb = 2'b11; e.alu = 4'b0010;
    end else if (k == K_LW || k == K_SW || k == K_ADDI) begin
      if (c == 2) begin
        e.asa = 1; e.asb = 2'b10; e.alu = 4'b0010;
      end else if (k == K_LW && c == 3) e.iord = 1;
      else if (k == K_LW) begin e.m2r = 1; e.we = 1; end
      else if (k == K_SW) begin e.iord = 1; e.mw = 1; end
      else e.we = 1;
    end else if (k == K_R) begin
      if (c == 2) begin e.asa = 1; e.alu = alu_of(fn); end
      else begin e.rdst = 1; e.we = 1; end
    end else if (k == K_BEQ) begin
      e.asa = 1; e.alu = 4'b0110; e.pcs = 2'b01; e.dff = z;
    end else if (k == K_J) begin
      e.pcs = 2'b10; e.dff = 1;
    end
    return e;
  endfunction

  // Entered just after a rising edge with the FSM in FETCH.
  task automatic run_instr(input int k, input logic [5:0] op,
                           input logic [5:0] fn, input logic z);
    opcode = op; funct = fn; zero = z;
    for (int c = 0; c < lat(k); c++) begin
      @(negedge clk);
      chk($sformatf("k%0d_c%0d", k, c), 32'(obs), 32'(expv(k, c, fn, z)));
      @(posedge clk); #1;
    end
    if (k != K_ILL) m_cnt = (m_cnt + 1) % (1 << CW);
    if (k == K_ILL || (k == K_R && !fn_legal(fn))) m_ill = 1'b1;
    chk("cnt", 32'(instrCount), 32'(m_cnt));
    chk("ill", 32'(illegal), 32'(m_ill));
  endtask

  initial begin
    int k;
    logic [5:0] op;
    logic [5:0] fn;
    reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'(obs), 32'h0);
    chk("rst_cnt", 32'(instrCount), 32'h0);
    chk("rst_ill", 32'(illegal), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_instr(K_LW, op_of(K_LW), 6'b000000, 1'b0);
    run_instr(K_R, 6'b000000, 6'b100010, 1'b0);
    run_instr(K_R, 6'b000000, 6'b101010, 1'b0);
    run_instr(K_BEQ, op_of(K_BEQ), 6'b000000, 1'b1);
    run_instr(K_BEQ, op_of(K_BEQ), 6'b000000, 1'b0);
    run_instr(K_ADDI, op_of(K_ADDI), 6'b000000, 1'b0);
    run_instr(K_ILL, 6'b111111, 6'b000000, 1'b0);
    run_instr(K_J, op_of(K_J), 6'b000000, 1'b0);

    // Abort a store in its write cycle.
    opcode = op_of(K_SW); funct = '0; zero = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("swab_c%0d", c), 32'(obs),
          32'(expv(K_SW, c, 6'b0, 1'b0)));
      if (c < 3) begin @(posedge clk); #1; end
    end
    #1 reset = 1'b0;
    #1;
    m_cnt = 0; m_ill = 1'b0;
    chk("abort_mw", 32'(memWrite), 32'h0);
    chk("abort_out", 32'(obs), 32'h0);
    chk("abort_cnt", 32'(instrCount), 32'h0);
    chk("abort_ill", 32'(illegal), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 16; i++)
      run_instr(K_J, op_of(K_J), 6'b000000, 1'b0);
    chk("wrap", 32'(instrCount), 32'h0);

    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 6));
      op = op_of(k);
      fn = 6'($urandom);
      if (k == K_ILL) begin
        op = 6'($urandom);
        while (op inside {6'b100011, 6'b101011, 6'b000000,
                          6'b000100, 6'b001000, 6'b000010})
          op = 6'($urandom);
      end
      if (k == K_R && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: fn = 6'b100000;
          1: fn = 6'b100010;
          2: fn = 6'b100100;
          3: fn = 6'b100101;
          default: fn = 6'b101010;
        endcase
      end
      run_instr(k, op, fn, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
